xilly_hls_in_bridge: RTL

XILLY_HLS_IN_BRIDGE -- requirements
Module: xilly_hls_in_bridge

---
 rtl/xilly_bridge_pkg.sv | 21 ++
 rtl/xilly_sync_fifo.sv | 87 ++++++++
 rtl/xilly_hls_in_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/xilly_bridge_pkg.sv
// Shared constants and helpers for the Xillybus host-to-HLS stream bridge.
package xilly_bridge_pkg;

  localparam int DEF_HOST_W       = 8;
  localparam int DEF_RATIO        = 4;
  localparam int DEF_DEPTH        = 512;
  localparam int DEF_PAD_ON_CLOSE = 1;

  // Ceiling log2, usable in parameter/localparam elaboration.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/xilly_sync_fifo.sv
// Single-clock FIFO with occupancy count, registered full flag and
// synchronous clear. Read data is the current head (look-ahead).
module xilly_sync_fifo
  import xilly_bridge_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [AW:0]      count_next_s;

  // Qualify requests against occupancy and work out the next count.
  always_comb begin
    push_ok_s    = push & (count_r != FULL_CNT) & ~clr;
    pop_ok_s     = pop & (count_r != {(AW+1){1'b0}}) & ~clr;
    count_next_s = count_r;
    if (clr) begin
      count_next_s = {(AW+1){1'b0}};
    end else if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_ok_s && !push_ok_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage array; contents never need a reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, count and full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == FULL_CNT);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;
  assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/xilly_hls_in_bridge.sv
// Packs narrow Xillybus host-stream words into wide HLS words and presents
// them on an ap_fifo style interface through a FIFO and an output register.
module xilly_hls_in_bridge
  import xilly_bridge_pkg::*;
#(
  parameter int HOST_W       = DEF_HOST_W,
  parameter int RATIO        = DEF_RATIO,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int PAD_ON_CLOSE = DEF_PAD_ON_CLOSE,
  localparam int HLS_W       = HOST_W * RATIO,
  localparam int AW          = clog2_f(DEPTH)
) (
  input  logic              bus_clk,
  input  logic              ap_rst,
  input  logic              user_w_open,
  input  logic              user_w_wren,
  input  logic [HOST_W-1:0] user_w_data,
  output logic              user_w_full,
  output logic [HLS_W-1:0]  hls_dout,
  output logic              hls_empty_n,
  input  logic              hls_read,
  output logic [AW:0]       fill_level,
  output logic              overflow_err
);

  // Slot counter width; a single-slot packer still gets a 1-bit counter.
  localparam int            CW        = (RATIO > 1) ? clog2_f(RATIO) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);
  localparam logic [CW-1:0] SLOT_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic          PAD_EN    = (PAD_ON_CLOSE != 0);

  logic              open_q_r;
  logic [CW-1:0]     slot_cnt_r;
  logic [HLS_W-1:0]  pack_r;
  logic [HLS_W-1:0]  dout_r;
  logic              empty_n_r;
  logic [AW:0]       fill_r;
  logic              ovf_r;

  logic [HLS_W-1:0]  fifo_dout_s;
  logic [AW:0]       fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  logic              close_s;
  logic              reopen_s;
  logic              accept_s;
  logic              drop_s;
  logic              word_done_s;
  logic              has_partial_s;
  logic              pad_push_s;
  logic              pad_drop_s;
  logic              push_s;
  logic              pop_s;
  logic [HLS_W-1:0]  merged_s;
  logic [HLS_W-1:0]  push_word_s;
  logic              empty_n_next_s;
  logic [AW:0]       count_next_s;
  logic [AW:0]       fill_next_s;

  // Stream open/close edges, write qualification and close-time padding.
  always_comb begin
    close_s       = open_q_r & ~user_w_open;
    reopen_s      = ~open_q_r & user_w_open;
    // The reopen edge itself only clears state; data is taken from the next cycle.
    accept_s      = user_w_wren & user_w_open & open_q_r & ~fifo_full_s;
    drop_s        = user_w_wren & user_w_open & fifo_full_s;
    word_done_s   = accept_s & (slot_cnt_r == LAST_SLOT);
    has_partial_s = (slot_cnt_r != {CW{1'b0}});
    pad_push_s    = close_s & has_partial_s & PAD_EN & ~fifo_full_s;
    pad_drop_s    = close_s & has_partial_s & PAD_EN & fifo_full_s;
    push_s        = word_done_s | pad_push_s;
  end

  // Little-endian merge of the incoming host word into the current slot.
  always_comb begin
    merged_s = pack_r;
    for (int i = 0; i < RATIO; i++) begin
      if (slot_cnt_r == CW'(i)) begin
        merged_s[i*HOST_W +: HOST_W] = user_w_data;
      end else begin
        merged_s[i*HOST_W +: HOST_W] = pack_r[i*HOST_W +: HOST_W];
      end
    end
    // A padded word is pack_r as-is: unused upper slots are held at zero.
    if (word_done_s) begin
      push_word_s = merged_s;
    end else begin
      push_word_s = pack_r;
    end
  end

  // Output-register load/drain and the occupancy that results.
  always_comb begin
    pop_s = ~fifo_empty_s & (hls_read | ~empty_n_r) & ~reopen_s;
    if (reopen_s) begin
      empty_n_next_s = 1'b0;
    end else if (pop_s) begin
      empty_n_next_s = 1'b1;
    end else if (hls_read) begin
      empty_n_next_s = 1'b0;
    end else begin
      empty_n_next_s = empty_n_r;
    end
    if (reopen_s) begin
      count_next_s = {(AW+1){1'b0}};
    end else if (push_s && !pop_s) begin
      count_next_s = fifo_count_s + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = fifo_count_s - CNT_ONE;
    end else begin
      count_next_s = fifo_count_s;
    end
    fill_next_s = count_next_s + {{AW{1'b0}}, empty_n_next_s};
  end

  xilly_sync_fifo #(
    .WIDTH (HLS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (bus_clk),
    .rst   (ap_rst),
    .clr   (reopen_s),
    .push  (push_s),
    .din   (push_word_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Open history and packer slot state.
  always_ff @(posedge bus_clk or posedge ap_rst) begin
    if (ap_rst) begin
      open_q_r   <= 1'b0;
      slot_cnt_r <= {CW{1'b0}};
      pack_r     <= {HLS_W{1'b0}};
    end else begin
      open_q_r <= user_w_open;
      if (reopen_s || close_s || word_done_s) begin
        slot_cnt_r <= {CW{1'b0}};
        pack_r     <= {HLS_W{1'b0}};
      end else if (accept_s) begin
        slot_cnt_r <= slot_cnt_r + SLOT_ONE;
        pack_r     <= merged_s;
      end
    end
  end

  // ap_fifo output register, fill level and sticky overflow flag.
  always_ff @(posedge bus_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dout_r    <= {HLS_W{1'b0}};
      empty_n_r <= 1'b0;
      fill_r    <= {(AW+1){1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      if (reopen_s) begin
        dout_r <= {HLS_W{1'b0}};
      end else if (pop_s) begin
        dout_r <= fifo_dout_s;
      end
      empty_n_r <= empty_n_next_s;
      fill_r    <= fill_next_s;
      ovf_r     <= ovf_r | drop_s | pad_drop_s;
    end
  end

  assign user_w_full  = fifo_full_s;
  assign hls_dout     = dout_r;
  assign hls_empty_n  = empty_n_r;
  assign fill_level   = fill_r;
  assign overflow_err = ovf_r;

endmodule
